// File: rtl/mem_access_unit.sv
// Data-memory access unit: one load/store per request on a word-only bus.
// Sub-word loads are extracted and extended; sb/sh use read-modify-write.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        wena,
  input  logic        w,
  input  logic        h,
  input  logic        b,
  input  logic        z,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        done,
  output logic        misalign,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_DONE
  } state_t;

  localparam logic [7:0] LP_TO = 8'(TIMEOUT);

  state_t      r_state;
  logic [31:0] r_addr;
  logic [15:0] r_wdata;
  logic        r_w;
  logic        r_h;
  logic        r_b;
  logic        r_z;
  logic        r_wena;
  logic [7:0]  r_cnt;
  logic [31:0] r_rdata;
  logic        r_done;
  logic        r_misalign;
  logic        r_bus_err;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [31:0] r_mem_wdata;

  logic        w_one;
  logic        w_fault;
  logic [4:0]  w_bsh;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [31:0] w_merge;
  logic [7:0]  w_cnt_nxt;
  logic        w_to;

  // Request decode on the live inputs, evaluated while idle
  assign w_one = (w & ~h & ~b)
               | (~w & h & ~b)
               | (~w & ~h & b);

  assign w_fault = ~w_one
                 | (h & addr[0])
                 | (w & (addr[1:0] != 2'b00));

  // Lane selection from the latched address
  assign w_bsh  = {r_addr[1:0], 3'b000};
  assign w_byte = mem_rdata[w_bsh +: 8];
  assign w_half = r_addr[1] ? mem_rdata[31:16]
                            : mem_rdata[15:0];

  assign w_cnt_nxt = r_cnt + 8'd1;
  assign w_to      = (w_cnt_nxt == LP_TO);

  // Load result: word pass-through or sign/zero-extended lane
  always_comb begin
    w_load = mem_rdata;
    if (r_w) begin
      w_load = mem_rdata;
    end else if (r_h) begin
      w_load = {{16{~r_z & w_half[15]}}, w_half};
    end else begin
      w_load = {{24{~r_z & w_byte[7]}}, w_byte};
    end
  end

  // Store merge: replace the addressed lane of the read word
  always_comb begin
    w_merge = mem_rdata;
    if (r_b) begin
      w_merge[w_bsh +: 8] = r_wdata[7:0];
    end else if (r_addr[1]) begin
      w_merge[31:16] = r_wdata;
    end else begin
      w_merge[15:0] = r_wdata;
    end
  end

  // Access sequencer with registered bus and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_w         <= 1'b0;
      r_h         <= 1'b0;
      r_b         <= 1'b0;
      r_z         <= 1'b0;
      r_wena      <= 1'b0;
      r_cnt       <= '0;
      r_rdata     <= '0;
      r_done      <= 1'b0;
      r_misalign  <= 1'b0;
      r_bus_err   <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_addr  <= addr;
            r_wdata <= wdata[15:0];
            r_w     <= w;
            r_h     <= h;
            r_b     <= b;
            r_z     <= z;
            r_wena  <= wena;
            r_cnt   <= '0;
            if (w_fault) begin
              r_state    <= S_DONE;
              r_done     <= 1'b1;
              r_misalign <= 1'b1;
              r_rdata    <= '0;
            end else if (wena & w) begin
              r_state     <= S_WR;
              r_mem_req   <= 1'b1;
              r_mem_we    <= 1'b1;
              r_mem_wdata <= wdata;
            end else begin
              r_state   <= S_RD;
              r_mem_req <= 1'b1;
              r_mem_we  <= 1'b0;
            end
          end
        end
        S_RD: begin
          if (mem_ack) begin
            r_cnt <= '0;
            if (r_wena) begin
              r_state     <= S_WR;
              r_mem_we    <= 1'b1;
              r_mem_wdata <= w_merge;
            end else begin
              r_state   <= S_DONE;
              r_mem_req <= 1'b0;
              r_done    <= 1'b1;
              r_rdata   <= w_load;
            end
          end else if (w_to) begin
            r_state   <= S_DONE;
            r_mem_req <= 1'b0;
            r_done    <= 1'b1;
            r_bus_err <= 1'b1;
            r_rdata   <= '0;
          end else begin
            r_cnt <= w_cnt_nxt;
          end
        end
        S_WR: begin
          if (mem_ack) begin
            r_state   <= S_DONE;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_done    <= 1'b1;
            r_rdata   <= '0;
          end else if (w_to) begin
            r_state   <= S_DONE;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_done    <= 1'b1;
            r_bus_err <= 1'b1;
            r_rdata   <= '0;
          end else begin
            r_cnt <= w_cnt_nxt;
          end
        end
        S_DONE: begin
          r_state    <= S_IDLE;
          r_done     <= 1'b0;
          r_misalign <= 1'b0;
          r_bus_err  <= 1'b0;
          r_rdata    <= '0;
          r_mem_we   <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Hold the pipeline from request acceptance until completion
  assign stall = rst_n
               & (((r_state == S_IDLE) & start)
               | (r_state == S_RD)
               | (r_state == S_WR));

  assign rdata     = r_rdata;
  assign done      = r_done;
  assign misalign  = r_misalign;
  assign bus_err   = r_bus_err;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = {r_addr[31:2], 2'b00};
  assign mem_wdata = r_mem_wdata;

endmodule
